vip_tpg: RTL and testbench
==========================

Name: vip_tpg

Overview:
- Video test-pattern generator: the transmitter side of the pipeline's href/vsync/data pixel-stream protocol.
- Produces complete frames with programmable sync and blanking intervals, and fills active pixels from a selectable synthetic pattern.
- Sits at the head of the VIP chain, replacing the sensor input for bring-up and regression. Its output drives crop and any other stream consumer directly.

Parameters:
- BITS, 8: pixel width; must be >= 4.
- WIDTH, 1280: active pixels per line.
- HEIGHT, 960: active lines per frame.
- HBLANK, 160: blank cycles per line after active pixels; must be >= 1.
- VSYNC_LINES, 2: lines with vsync high; must be >= 1.
- VBP_LINES, 8: blank lines after vsync, before active; must be >= 1.
- VFP_LINES, 4: blank lines after active; must be >= 1.
- CHK_LOG2, 4: checker block size, 2^CHK_LOG2 pixels/lines.

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run request; sampled only in IDLE and on the last cycle of a frame.
- pattern_sel  in  2  0 = solid, 1 = ramp, 2 = gray bars, 3 = checker; latched at frame start.
- solid_val  in  BITS  solid fill value; latched at frame start.
- out_href  out  1  active-pixel qualifier.
- out_vsync  out  1  frame sync; the frame begins on its falling edge from the consumer's view.
- out_data  out  BITS  pixel; valid when out_href=1, otherwise 0.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- busy  out  1  1 while a frame is in progress.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset is asynchronous; asserting it mid-frame aborts immediately with outputs 0.
- Timing definitions:
  - LT = WIDTH + HBLANK cycles per line.
  - NL = VSYNC_LINES + VBP_LINES + HEIGHT + VFP_LINES lines per frame.
  - FT = NL * LT cycles per frame.
  - Counters: h_cnt 0..LT-1, v_cnt 0..NL-1, 16 bits each, wrapping at LT and NL.
- FSM states: IDLE, SYNC, BP, ACTIVE, FP.
  - IDLE -> SYNC when enable=1.
  - SYNC -> BP after VSYNC_LINES lines.
  - BP -> ACTIVE after VBP_LINES lines.
  - ACTIVE -> FP after HEIGHT lines.
  - FP -> SYNC at end of last line if enable=1, else -> IDLE.
  - Deasserting enable mid-frame has no effect; the current frame completes.
- All outputs are registered. Frame cycle 0 is the first cycle out_vsync=1.
  - If enable is sampled high in IDLE at cycle t, frame cycle 0 is t+2.
  - Back-to-back frames have no gap: cycle FT-1 of frame N is immediately followed by cycle 0 of frame N+1.
- out_vsync = 1 for frame cycles 0 .. VSYNC_LINES*LT-1.
- Active line k (k = 0..HEIGHT-1) starts at cycle (VSYNC_LINES+VBP_LINES+k)*LT. On that line, out_href = 1 for exactly WIDTH consecutive cycles, then 0 for HBLANK cycles. out_href is never 1 while out_vsync = 1.
- frame_done = 1 only at cycle FT-1. busy = 1 from cycle 0 through FT-1, and stays 1 across back-to-back frames.
- Pixel coordinates: x = h_cnt within the active region (0..WIDTH-1); y = active line index k.
- Patterns (pattern_sel and solid_val are latched at frame cycle 0 and held for the whole frame):
  - 0 solid: out_data = latched solid_val.
  - 1 ramp: out_data = x[BITS-1:0]; wraps every 2^BITS pixels.
  - 2 gray bars: BAR_W = WIDTH/8 (integer). bar = x/BAR_W, saturated at 7. Implement with a bar counter, not a divider. out_data = {~bar[2:0], {(BITS-3){~bar[0]}}}, so bar 0 = all ones and bar 7 = all zeros.
  - 3 checker: out_data = all ones if (x[CHK_LOG2] ^ y[CHK_LOG2]) else 0.
- Outside active pixels out_data = 0.

Decomposition:
- Package vip_tpg_pkg:
  - FSM state encoding (3-bit).
  - Pattern codes PAT_SOLID = 0, PAT_RAMP = 1, PAT_BARS = 2, PAT_CHECK = 3.
- Sub-module vip_tpg_pattern: combinational/registered pixel generator.
  - Inputs: x, y, line_start, pattern, solid value.
  - Holds the bar counter.
  - The top level keeps the FSM and counters, and aligns the 1-cycle registered output.

Test Plan (bench parameters WIDTH=16, HEIGHT=4, HBLANK=4, VSYNC=1, VBP=1, VFP=1, giving LT=20, FT=140; CHK_LOG2=1 for scenario 5):
- Single frame: enable pulsed high at cycle t in IDLE -> out_vsync high for 20 cycles from t+2; exactly 4 href bursts of 16 cycles starting at frame cycles 40, 60, 80, 100; frame_done at frame cycle 139; then busy=0.
- Continuous run: enable held high -> frames back-to-back with period 140 cycles; frame_done every 140 cycles; busy stays 1; enable dropped mid-frame -> that frame completes and no further vsync follows.
- Patterns:
  - Ramp: each active line reads 0..15.
  - Bars (BAR_W=2): pixels 0,1 = 0xFF; pixels 14,15 = 0x00.
  - Solid with solid_val=0xA5: all active pixels 0xA5. Changing solid_val mid-frame does not change output until the next frame.
- Checker (CHK_LOG2=1): line 0 pixels 0,1 = 0x00 and pixels 2,3 = 0xFF; line 2 is the inverse of line 0.
- Reset asserted during active line 2 -> all outputs 0 asynchronously. After release with enable=1, a full fresh frame starts with correct timing.
- Loopback into the crop block with window x=4, y=1, w=8, h=2 -> 2 lines of 8 pixels; ramp values 4..11 on each line.

Source files
------------

// File: rtl/vip_tpg_pkg.sv
// Shared types for the video test-pattern generator.
//   tpg_state_e : frame FSM states (3-bit encoding)
//   PAT_*       : pattern_sel codes
package vip_tpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BP     = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FP     = 3'd4
    } tpg_state_e;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

endpackage

// File: rtl/vip_tpg_pattern.sv
// Pixel generator for vip_tpg. Produces one registered pixel per cycle from
// the current coordinates; the output is zero whenever pix_en_i is low.
// Ports:
//   pclk, rst_n    : clock, asynchronous active-low reset
//   pix_en_i       : current cycle is an active pixel
//   line_start_i   : current cycle is pixel x=0 of an active line
//   x_i, y_i       : pixel coordinates within the active region
//   pattern_i      : pattern code (PAT_*)
//   solid_i        : fill value for the solid pattern
//   data_o         : registered pixel, one cycle after the coordinates
module vip_tpg_pattern
    import vip_tpg_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int WIDTH    = 1280,
    parameter int CHK_LOG2 = 4
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            pix_en_i,
    input  logic            line_start_i,
    input  logic [15:0]     x_i,
    input  logic [15:0]     y_i,
    input  logic [1:0]      pattern_i,
    input  logic [BITS-1:0] solid_i,
    output logic [BITS-1:0] data_o
);

    // A bar width of 0 (WIDTH < 8) would never advance; clamp to 1.
    localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

    logic [2:0]      bar_q, bar_d, cur_bar;
    logic [15:0]     cnt_q, cnt_d, cur_cnt;
    logic [BITS-1:0] pix;
    logic [BITS-1:0] data_q;

    // Only some coordinate bits feed a pattern; the rest are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{x_i, y_i};

    // bar_q/cnt_q describe the pixel after the previous one; line_start
    // restarts them so stale state from the previous line never leaks.
    always_comb begin
        cur_bar = line_start_i ? 3'd0  : bar_q;
        cur_cnt = line_start_i ? 16'd0 : cnt_q;
        bar_d   = cur_bar;
        cnt_d   = cur_cnt;
        if (cur_bar != 3'd7) begin
            if (cur_cnt == 16'(BAR_W - 1)) begin
                bar_d = cur_bar + 3'd1;
                cnt_d = '0;
            end else begin
                cnt_d = cur_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (pattern_i)
            PAT_RAMP:  pix = x_i[BITS-1:0];
            PAT_BARS:  pix = {~cur_bar, {(BITS-3){~cur_bar[0]}}};
            PAT_CHECK: pix = {BITS{x_i[CHK_LOG2] ^ y_i[CHK_LOG2]}};
            default:   pix = solid_i;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            if (pix_en_i) begin
                bar_q <= bar_d;
                cnt_q <= cnt_d;
            end
            data_q <= pix_en_i ? pix : '0;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/vip_tpg.sv
// Video test-pattern generator: emits complete href/vsync/data frames with
// programmable sync and blanking, active pixels filled from a synthetic pattern.
// Ports:
//   pclk, rst_n  : pixel clock, asynchronous active-low reset
//   enable       : run request, sampled in IDLE and on the last frame cycle
//   pattern_sel  : 0 solid, 1 ramp, 2 gray bars, 3 checker (latched per frame)
//   solid_val    : solid fill value (latched per frame)
//   out_href     : active-pixel qualifier
//   out_vsync    : frame sync, high for the first VSYNC_LINES lines
//   out_data     : pixel, zero outside active pixels
//   frame_done   : one-cycle pulse on the last cycle of each frame
//   busy         : high while a frame is in progress
module vip_tpg
    import vip_tpg_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int HBLANK      = 160,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 8,
    parameter int VFP_LINES   = 4,
    parameter int CHK_LOG2    = 4
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      pattern_sel,
    input  logic [BITS-1:0] solid_val,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data,
    output logic            frame_done,
    output logic            busy
);

    localparam int LT    = WIDTH + HBLANK;
    localparam int V_ACT = VSYNC_LINES + VBP_LINES;
    localparam int V_FP  = V_ACT + HEIGHT;
    localparam int NL    = V_FP + VFP_LINES;

    tpg_state_e      state_q;
    logic [15:0]     h_q, v_q;
    logic [1:0]      pat_q;
    logic [BITS-1:0] solid_q;
    logic            vsync_q, href_q, done_q, busy_q;

    logic line_end, frame_last, pix_en, line_start;

    assign line_end   = (h_q == 16'(LT - 1));
    assign frame_last = (state_q == ST_FP) && line_end && (v_q == 16'(NL - 1));
    assign pix_en     = (state_q == ST_ACTIVE) && (h_q < 16'(WIDTH));
    assign line_start = pix_en && (h_q == 16'd0);

    // Counters and state run one cycle ahead of the pins; every output,
    // including the pixel from the pattern block, is registered once so
    // they all line up.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            pat_q   <= PAT_SOLID;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vsync_q <= (state_q == ST_SYNC);
            href_q  <= pix_en;
            done_q  <= frame_last;
            busy_q  <= (state_q != ST_IDLE);

            if (state_q != ST_IDLE) begin
                h_q <= line_end ? 16'd0 : h_q + 16'd1;
                if (line_end)
                    v_q <= (v_q == 16'(NL - 1)) ? 16'd0 : v_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_SYNC;
                        h_q     <= '0;
                        v_q     <= '0;
                        pat_q   <= pattern_sel;
                        solid_q <= solid_val;
                    end
                end
                ST_SYNC: begin
                    if (line_end && v_q == 16'(VSYNC_LINES - 1))
                        state_q <= ST_BP;
                end
                ST_BP: begin
                    if (line_end && v_q == 16'(V_ACT - 1))
                        state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (line_end && v_q == 16'(V_FP - 1))
                        state_q <= ST_FP;
                end
                ST_FP: begin
                    // Counters wrap to 0 here by themselves, so a restart
                    // needs no gap cycle.
                    if (frame_last) begin
                        if (enable) begin
                            state_q <= ST_SYNC;
                            pat_q   <= pattern_sel;
                            solid_q <= solid_val;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    vip_tpg_pattern #(
        .BITS     (BITS),
        .WIDTH    (WIDTH),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .pix_en_i     (pix_en),
        .line_start_i (line_start),
        .x_i          (h_q),
        .y_i          (v_q - 16'(V_ACT)),
        .pattern_i    (pat_q),
        .solid_i      (solid_q),
        .data_o       (out_data)
    );

    assign out_href   = href_q;
    assign out_vsync  = vsync_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vip_tpg.sv
// Self-checking bench for vip_tpg with a small frame geometry
// (16x4 active, LT=20, FT=140, checker blocks of 2).
module tb_vip_tpg;

    localparam int BITS = 8;
    localparam int W    = 16;
    localparam int H    = 4;
    localparam int HB   = 4;
    localparam int VS   = 1;
    localparam int VBP  = 1;
    localparam int VFP  = 1;
    localparam int CHK  = 1;
    localparam int LT   = W + HB;
    localparam int NL   = VS + VBP + H + VFP;
    localparam int FT   = NL * LT;

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      pattern_sel = 2'd0;
    logic [BITS-1:0] solid_val = '0;
    logic            out_href, out_vsync, frame_done, busy;
    logic [BITS-1:0] out_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] cap [0:H-1][0:W-1];

    always #5 pclk = ~pclk;

    vip_tpg #(
        .BITS(BITS), .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .CHK_LOG2(CHK)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_val(solid_val),
        .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data),
        .frame_done(frame_done), .busy(busy)
    );

    // Reference pixel from the pattern definitions.
    function automatic logic [7:0] exp_pix(input int pat, input logic [7:0] solid,
                                           input int x, input int y);
        int bar;
        logic [2:0] b;
        case (pat)
            0: return solid;
            1: return 8'(x % 256);
            2: begin
                bar = x / (W / 8);
                if (bar > 7) bar = 7;
                b = 3'(bar);
                return {~b, {5{~b[0]}}};
            end
            default: return ((((x >> CHK) & 1) ^ ((y >> CHK) & 1)) != 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // Called on the negedge right after enable (or reset release) is applied;
    // returns on the negedge of frame cycle 0.
    task automatic wait_start(input string tag);
        @(negedge pclk);
        n_total++;
        if (out_vsync !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_latency: vsync=%b busy=%b one cycle after enable, want 0/0", tag, out_vsync, busy);
        else n_pass++;
        @(negedge pclk);
    endtask

    // Walks one frame cycle by cycle from frame cycle 0, comparing every pin
    // with the timing model. Returns on the negedge of cycle FT.
    task automatic run_frame(input string tag, input int pat, input logic [7:0] solid,
                             input int drop_en_at, input int poke_solid_at);
        int line, h, y;
        logic ev, eh, edn;
        logic [7:0] ed;
        for (int fc = 0; fc < FT; fc++) begin
            line = fc / LT;
            h    = fc % LT;
            y    = line - (VS + VBP);
            ev   = (line < VS);
            eh   = (line >= VS + VBP) && (line < VS + VBP + H) && (h < W);
            ed   = eh ? exp_pix(pat, solid, h, y) : 8'h00;
            edn  = (fc == FT - 1);
            n_total++;
            if ({out_vsync, out_href, out_data, frame_done, busy} !== {ev, eh, ed, edn, 1'b1})
                $display("FAIL %s fc=%0d got vs/href/data/done/busy=%b/%b/%h/%b/%b want %b/%b/%h/%b/1",
                         tag, fc, out_vsync, out_href, out_data, frame_done, busy, ev, eh, ed, edn);
            else n_pass++;
            if (eh) cap[y][h] = out_data;
            if (fc == drop_en_at) enable = 1'b0;
            if (fc == poke_solid_at) solid_val = ~solid;
            @(negedge pclk);
        end
    endtask

    // After a final frame: idle, no further vsync for a while.
    task automatic check_idle(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_vsync !== 1'b0 || busy !== 1'b0 || out_href !== 1'b0) seen++;
            @(negedge pclk);
        end
        n_total++;
        if (seen != 0) $display("FAIL %s_idle: %0d active cycles after last frame, want 0", tag, seen);
        else n_pass++;
    endtask

    task automatic single_frame(input string tag, input int pat, input logic [7:0] solid,
                                input int poke_at);
        pattern_sel = 2'(pat);
        solid_val   = solid;
        enable      = 1'b1;
        wait_start(tag);
        run_frame(tag, pat, solid, 0, poke_at);
    endtask

    task automatic test_reset;
        @(negedge pclk);
        @(negedge pclk);
        n_total++;
        if ({out_vsync, out_href, out_data, frame_done, busy} !== 12'h000)
            $display("FAIL reset_outputs: got %b/%b/%h/%b/%b want all 0",
                     out_vsync, out_href, out_data, frame_done, busy);
        else n_pass++;
        rst_n = 1'b1;
        check_idle("reset");
    endtask

    task automatic test_single_frame;
        single_frame("single", 1, 8'h00, -1);
        check_idle("single");
    endtask

    task automatic test_patterns;
        single_frame("bars", 2, 8'h00, -1);
        n_total++;
        if ({cap[0][0], cap[0][1], cap[0][14], cap[0][15]} !== 32'hFFFF_0000)
            $display("FAIL bars_edges: got %h %h %h %h want ff ff 00 00",
                     cap[0][0], cap[0][1], cap[0][14], cap[0][15]);
        else n_pass++;

        single_frame("solid", 0, 8'hA5, 50);
        n_total++;
        if (cap[3][15] !== 8'hA5) $display("FAIL solid_hold: got %h want a5", cap[3][15]);
        else n_pass++;

        single_frame("checker", 3, 8'h00, -1);
        n_total++;
        if ({cap[0][0], cap[0][1], cap[0][2], cap[0][3]} !== 32'h0000_FFFF)
            $display("FAIL checker_line0: got %h %h %h %h want 00 00 ff ff",
                     cap[0][0], cap[0][1], cap[0][2], cap[0][3]);
        else n_pass++;
        for (int x = 0; x < W; x++) begin
            n_total++;
            if (cap[2][x] !== ~cap[0][x])
                $display("FAIL checker_inverse x=%0d: got %h want %h", x, cap[2][x], ~cap[0][x]);
            else n_pass++;
        end
        check_idle("patterns");
    endtask

    task automatic test_back_to_back;
        logic [7:0] s;
        s = 8'($urandom);
        pattern_sel = 2'd0;
        solid_val   = s;
        enable      = 1'b1;
        wait_start("b2b");
        run_frame("b2b_f1", 0, s, -1, -1);
        run_frame("b2b_f2", 0, s, 70, -1);
        check_idle("b2b");
    endtask

    task automatic test_random_patterns;
        int p;
        logic [7:0] s;
        for (int i = 0; i < 4; i++) begin
            p = int'($urandom_range(0, 3));
            s = 8'($urandom);
            single_frame("random", p, s, -1);
        end
        check_idle("random");
    endtask

    task automatic test_reset_midframe;
        pattern_sel = 2'd1;
        enable      = 1'b1;
        wait_start("rst_mid");
        for (int i = 0; i < 85; i++) @(negedge pclk);
        n_total++;
        if (out_href !== 1'b1 || busy !== 1'b1)
            $display("FAIL rst_mid_pre: href/busy=%b/%b want 1/1", out_href, busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_vsync, out_href, out_data, frame_done, busy} !== 12'h000)
            $display("FAIL rst_mid_async: got %b/%b/%h/%b/%b want all 0",
                     out_vsync, out_href, out_data, frame_done, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) @(negedge pclk);
        n_total++;
        if ({out_vsync, out_href, out_data, frame_done, busy} !== 12'h000)
            $display("FAIL rst_mid_held: got %b/%b/%h/%b/%b want all 0",
                     out_vsync, out_href, out_data, frame_done, busy);
        else n_pass++;
        rst_n = 1'b1;
        wait_start("rst_mid_restart");
        run_frame("rst_mid_frame", 1, 8'h00, 0, -1);
        check_idle("rst_mid");
    endtask

    // Consumer-side crop of a ramp frame: window x=4, y=1, 8x2.
    task automatic test_crop_loopback;
        single_frame("crop_src", 1, 8'h00, -1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                n_total++;
                if (cap[1 + r][4 + c] !== 8'(4 + c))
                    $display("FAIL crop r=%0d c=%0d: got %h want %h", r, c, cap[1 + r][4 + c], 8'(4 + c));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_patterns;
        test_back_to_back;
        test_random_patterns;
        test_reset_midframe;
        test_crop_loopback;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
